lc3_mem_responder: RTL and testbench
====================================

// Module: lc3_mem_responder
// PURPOSE
//  Memory-side responder for the LC-3 datapath bus. Serves MAR/MDR requests from the CPU
//  (CE/UB/LB/OE/WE, all active-low) with a fixed wait-state latency and a one-cycle ready pulse.
//  Backs a word-addressed on-chip RAM and one memory-mapped I/O word: read = switches, write = hex
//  display register. Sits between the datapath's MAR/MDR/MDR_In ports and the board I/O.
// PARAMETERS
//  ADDR_W       10        RAM address width; depth = 2**ADDR_W 16-bit words
//  WAIT_CYCLES  2         wait states between request accept and R pulse (0..15)
//  IO_ADDR      16'hFFFF  memory-mapped I/O address (switches read / hex write)
// PORTS
//  Clk            in   1   system clock, rising edge
//  Reset          in   1   asynchronous, active-low reset
//  CE             in   1   chip enable, active-low
//  UB             in   1   upper-byte enable, active-low (writes only)
//  LB             in   1   lower-byte enable, active-low (writes only)
//  OE             in   1   read request, active-low
//  WE             in   1   write request, active-low
//  ADDR           in   16  word address (from MAR)
//  Data_from_CPU  in   16  write data (from MDR)
//  Switches       in   16  board switches, returned on reads of IO_ADDR
//  Data_to_CPU    out  16  read data (to MDR_In); holds last read value
//  R              out  1   ready: one-cycle pulse on completion of a read or write
//  Busy           out  1   high from accept until the return to IDLE
//  HEX_Data       out  16  hex display register, written via IO_ADDR
// BEHAVIOUR
//  Reset (Reset=0, async): state=IDLE; Data_to_CPU=0, R=0, Busy=0, HEX_Data=0, wait counter=0.
//   RAM contents are not cleared.
//  Request = CE==0 && (OE==0 || WE==0). If WE==0 the request is a write (WE wins over OE);
//   otherwise it is a read.
//  FSM states: IDLE, WAIT, DONE, HOLD.
//  - IDLE: on a clock edge with a request, latch ADDR, Data_from_CPU, UB, LB and rd/wr. Go to
//     WAIT with count = WAIT_CYCLES-1, or directly to DONE if WAIT_CYCLES==0. Busy=1.
//  - WAIT: decrement count each cycle; at 0 go to DONE. Input changes here are ignored.
//  - DONE: exactly one cycle, R=1.
//     Write: RAM[addr] upper byte updated iff UB latched low, lower byte iff LB latched low.
//      Addr==IO_ADDR: HEX_Data gets the byte-enabled bytes instead.
//     Read: Data_to_CPU is registered on the DONE edge and held until the next read completes.
//      Addr==IO_ADDR returns Switches, sampled in DONE.
//     Go to HOLD.
//  - HOLD: R=0, Busy=1. Remain until the request drops (CE==1 or OE&WE==1), then go to IDLE.
//     A held request never re-triggers.
//  Latency: R rises WAIT_CYCLES+1 edges after the accept edge. Write data is visible to a read
//   accepted after HOLD exits.
//  Addresses >= 2**ADDR_W other than IO_ADDR: reads return 16'h0000, writes are dropped, and R
//   still pulses. Upper ADDR bits are not aliased.
//  UB=LB=1 on a write: no storage changes and R still pulses.
//  Reset mid-transaction: the transaction is aborted, any pending write is discarded, and the FSM
//   returns to IDLE.
// TESTING
//  Reset with Reset=0 -> Data_to_CPU=0, HEX_Data=0, R=0, Busy=0. Release, idle 5 cycles -> R stays 0.
//  WAIT_CYCLES=2: write 16'hBEEF to 0x0010 (UB=LB=0) -> R high on 3rd edge after accept, 1 cycle.
//   Then read 0x0010 -> Data_to_CPU=16'hBEEF.
//  Byte write 16'h12AB to 0x0010 with LB=0, UB=1 -> read returns 16'hBEAB.
//  Switches=16'h00A5, read IO_ADDR -> 16'h00A5. Write 16'h1234 to IO_ADDR -> HEX_Data=16'h1234;
//   RAM is unchanged.
//  Hold OE=0, CE=0 for 20 cycles -> exactly one R pulse. Deassert, reassert -> a second pulse.
//  Assert Reset during WAIT of a write of 16'h5555 to 0x0020 -> no R pulse, RAM[0x20] unchanged,
//   next request is served normally.

Source files
------------

// File: rtl/lc3_mem_responder.sv
// -----------------------------------------------------------------------------
// lc3_mem_responder
//
// Memory-side responder for the LC-3 datapath bus. Accepts a read or write
// request from the CPU (all control strobes active-low), waits a fixed number
// of wait states, then completes the access and pulses R for one cycle.
// Storage is a word-addressed on-chip RAM plus one memory-mapped I/O word:
// reads of IO_ADDR return the board switches, writes of IO_ADDR load the hex
// display register.
//
// Ports
//   Clk            in   1   system clock, rising edge
//   Reset          in   1   asynchronous reset, active-low
//   CE             in   1   chip enable, active-low
//   UB, LB         in   1   upper/lower byte enables, active-low (writes only)
//   OE             in   1   read request, active-low
//   WE             in   1   write request, active-low (wins over OE)
//   ADDR           in   16  word address (from MAR)
//   Data_from_CPU  in   16  write data (from MDR)
//   Switches       in   16  board switches, returned on reads of IO_ADDR
//   Data_to_CPU    out  16  read data (to MDR_In), holds the last read value
//   R              out  1   one-cycle ready pulse on completion
//   Busy           out  1   high from accept until the return to IDLE
//   HEX_Data       out  16  hex display register
// -----------------------------------------------------------------------------
module lc3_mem_responder #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CE,
  input  logic        UB,
  input  logic        LB,
  input  logic        OE,
  input  logic        WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic [15:0] Switches,
  output logic [15:0] Data_to_CPU,
  output logic        R,
  output logic        Busy,
  output logic [15:0] HEX_Data
);

  localparam int DEPTH = 1 << ADDR_W;

  // The WAIT state is skipped entirely when WAIT_CYCLES is 0, so the load
  // value only matters for WAIT_CYCLES >= 1.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_HOLD
  } state_t;

  state_t state;
  state_t next_state;

  logic        request;
  logic        load;
  logic [3:0]  wait_cnt;
  logic [15:0] addr_lat;
  logic [15:0] wdata_lat;
  logic        ub_en;
  logic        lb_en;
  logic        is_write;
  logic        io_hit;
  logic        in_range;
  logic [15:0] rd_word;

  logic [15:0] mem [0:DEPTH-1];

  assign request = !CE && (!OE || !WE);

  // Address decode works on the latched address so input changes during the
  // transaction cannot redirect it. Upper address bits are compared in full,
  // so out-of-range addresses never alias onto the RAM.
  assign io_hit   = (addr_lat == IO_ADDR);
  assign in_range = ({16'd0, addr_lat} < 32'(DEPTH));

  always_comb begin
    rd_word = 16'h0000;
    if (io_hit) begin
      rd_word = Switches;
    end else if (in_range) begin
      rd_word = mem[addr_lat[ADDR_W-1:0]];
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and status outputs. HOLD waits for the request to drop so a
  // request left asserted by the CPU is served only once.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    R          = 1'b0;
    Busy       = 1'b1;
    case (state)
      S_IDLE: begin
        Busy = 1'b0;
        if (request) begin
          load       = 1'b1;
          next_state = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        R          = 1'b1;
        next_state = S_HOLD;
      end
      S_HOLD: begin
        if (!request) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Request capture and wait-state counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wait_cnt  <= 4'd0;
      addr_lat  <= 16'h0000;
      wdata_lat <= 16'h0000;
      ub_en     <= 1'b0;
      lb_en     <= 1'b0;
      is_write  <= 1'b0;
    end else if (load) begin
      wait_cnt  <= WAIT_LOAD;
      addr_lat  <= ADDR;
      wdata_lat <= Data_from_CPU;
      ub_en     <= !UB;
      lb_en     <= !LB;
      is_write  <= !WE;
    end else if (state == S_WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Read data and hex register are updated on the edge that ends DONE.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Data_to_CPU <= 16'h0000;
      HEX_Data    <= 16'h0000;
    end else if (state == S_DONE) begin
      if (!is_write) begin
        Data_to_CPU <= rd_word;
      end else if (io_hit) begin
        if (ub_en) begin
          HEX_Data[15:8] <= wdata_lat[15:8];
        end
        if (lb_en) begin
          HEX_Data[7:0] <= wdata_lat[7:0];
        end
      end
    end
  end

  // RAM has no reset; a reset during a transaction forces IDLE before DONE
  // is reached, so the pending write never lands.
  always_ff @(posedge Clk) begin
    if (state == S_DONE && is_write && !io_hit && in_range) begin
      if (ub_en) begin
        mem[addr_lat[ADDR_W-1:0]][15:8] <= wdata_lat[15:8];
      end
      if (lb_en) begin
        mem[addr_lat[ADDR_W-1:0]][7:0] <= wdata_lat[7:0];
      end
    end
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_lc3_mem_responder
//
// Self-checking bench for lc3_mem_responder: a directed vector table, hand
// sequences for held requests and mid-transaction reset, and a randomized
// phase checked against a byte-level memory model.
// -----------------------------------------------------------------------------
module tb_lc3_mem_responder;

  localparam int          WAIT_CYCLES = 2;
  localparam logic [15:0] IO_ADDR     = 16'hFFFF;

  logic        Clk;
  logic        Reset;
  logic        CE;
  logic        UB;
  logic        LB;
  logic        OE;
  logic        WE;
  logic [15:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic [15:0] Switches;
  logic [15:0] Data_to_CPU;
  logic        R;
  logic        Busy;
  logic [15:0] HEX_Data;

  int n_checks = 0;
  int n_err    = 0;

  lc3_mem_responder #(
    .ADDR_W     (10),
    .WAIT_CYCLES(WAIT_CYCLES),
    .IO_ADDR    (IO_ADDR)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .CE           (CE),
    .UB           (UB),
    .LB           (LB),
    .OE           (OE),
    .WE           (WE),
    .ADDR         (ADDR),
    .Data_from_CPU(Data_from_CPU),
    .Switches     (Switches),
    .Data_to_CPU  (Data_to_CPU),
    .R            (R),
    .Busy         (Busy),
    .HEX_Data     (HEX_Data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        wr;
    logic        ub_n;
    logic        lb_n;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] sw;
    logic [15:0] exp_rd;
    logic [15:0] exp_hex;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    CE = 1'b1;
    OE = 1'b1;
    WE = 1'b1;
    UB = 1'b1;
    LB = 1'b1;
  endtask

  // One complete bus transaction: checks latency, pulse width and Busy,
  // releases the request and returns Data_to_CPU once back in IDLE.
  task automatic applyStimulus(input logic wr, input logic ub_n, input logic lb_n,
                               input logic [15:0] addr, input logic [15:0] data,
                               input logic oe_on_write, output logic [15:0] rd);
    int edges;
    @(negedge Clk);
    CE            = 1'b0;
    WE            = wr ? 1'b0 : 1'b1;
    OE            = wr ? oe_on_write : 1'b0;
    UB            = ub_n;
    LB            = lb_n;
    ADDR          = addr;
    Data_from_CPU = data;
    edges         = 0;
    while (edges < 20) begin
      @(negedge Clk);
      edges++;
      if (R) break;
    end
    check("latency", 16'(edges), 16'(WAIT_CYCLES + 1));
    check("busy_in_done", {15'd0, Busy}, 16'd1);
    @(negedge Clk);
    check("r_pulse_width", {15'd0, R}, 16'd0);
    idle_bus();
    ADDR          = $urandom;
    Data_from_CPU = $urandom;
    @(negedge Clk);
    check("busy_after_release", {15'd0, Busy}, 16'd0);
    rd = Data_to_CPU;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    check(name, act, exp);
  endtask

  // Behavioural model: 16 tracked RAM words, the hex register and the last
  // value returned to the CPU.
  logic [15:0] model_mem [0:15];
  logic [15:0] model_hex;
  logic [15:0] model_last;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic ub_n, input logic lb_n);
    int hi;
    int lo;
    hi = ub_n ? (int'(old) / 256) : (int'(d) / 256);
    lo = lb_n ? (int'(old) % 256) : (int'(d) % 256);
    return 16'(hi * 256 + lo);
  endfunction

  initial begin
    logic [15:0] rd;
    int          pulses;

    // Reset state
    Reset         = 1'b0;
    Switches      = 16'h0000;
    ADDR          = 16'h0000;
    Data_from_CPU = 16'h0000;
    idle_bus();
    repeat (3) @(negedge Clk);
    checkOutput("reset_data", Data_to_CPU, 16'h0000);
    checkOutput("reset_hex", HEX_Data, 16'h0000);
    checkOutput("reset_r", {15'd0, R}, 16'd0);
    checkOutput("reset_busy", {15'd0, Busy}, 16'd0);
    Reset = 1'b1;
    pulses = 0;
    repeat (5) begin
      @(negedge Clk);
      pulses += int'(R);
    end
    checkOutput("idle_no_r", 16'(pulses), 16'd0);

    // Directed vector table
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h12AB, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 16'h0000, 16'hBEAB, 16'h0000};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, IO_ADDR,  16'h0000, 16'h00A5, 16'h00A5, 16'h0000};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, IO_ADDR,  16'h1234, 16'h00A5, 16'h00A5, 16'h1234};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 16'h00A5, 16'hBEAB, 16'h1234};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0410, 16'h7777, 16'h0000, 16'hBEAB, 16'h1234};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'h0410, 16'h0000, 16'h0000, 16'h0000, 16'h1234};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 16'h0000, 16'hBEAB, 16'h1234};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 16'h0010, 16'hDEAD, 16'h0000, 16'hBEAB, 16'h1234};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 16'h0000, 16'hBEAB, 16'h1234};
    vecs[12] = '{1'b1, 1'b0, 1'b1, IO_ADDR,  16'hAB00, 16'h0000, 16'hBEAB, 16'hAB34};
    vecs[13] = '{1'b1, 1'b1, 1'b1, IO_ADDR,  16'hFFFF, 16'h0000, 16'hBEAB, 16'hAB34};

    for (int i = 0; i < 14; i++) begin
      Switches = vecs[i].sw;
      applyStimulus(vecs[i].wr, vecs[i].ub_n, vecs[i].lb_n, vecs[i].addr,
                    vecs[i].data, 1'b1, rd);
      checkOutput($sformatf("vec%0d_data", i), rd, vecs[i].exp_rd);
      checkOutput($sformatf("vec%0d_hex", i), HEX_Data, vecs[i].exp_hex);
    end

    // Held read request: exactly one pulse, then a second after re-assert
    @(negedge Clk);
    CE = 1'b0;
    OE = 1'b0;
    ADDR = 16'h0010;
    pulses = 0;
    repeat (20) begin
      @(negedge Clk);
      pulses += int'(R);
    end
    checkOutput("held_one_pulse", 16'(pulses), 16'd1);
    idle_bus();
    repeat (2) @(negedge Clk);
    CE = 1'b0;
    OE = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge Clk);
      pulses += int'(R);
    end
    checkOutput("reassert_pulse", 16'(pulses), 16'd1);
    idle_bus();
    repeat (2) @(negedge Clk);

    // Reset during the WAIT of a write
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0020, 16'hA0A0, 1'b1, rd);
    @(negedge Clk);
    CE = 1'b0;
    WE = 1'b0;
    UB = 1'b0;
    LB = 1'b0;
    ADDR = 16'h0020;
    Data_from_CPU = 16'h5555;
    @(negedge Clk);
    checkOutput("busy_in_wait", {15'd0, Busy}, 16'd1);
    Reset = 1'b0;
    #1;
    checkOutput("abort_busy", {15'd0, Busy}, 16'd0);
    idle_bus();
    pulses = 0;
    repeat (4) begin
      @(negedge Clk);
      pulses += int'(R);
    end
    Reset = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      pulses += int'(R);
    end
    checkOutput("abort_no_r", 16'(pulses), 16'd0);
    checkOutput("abort_hex_reset", HEX_Data, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 1'b1, rd);
    checkOutput("abort_ram_kept", rd, 16'hA0A0);

    // Randomized phase against the behavioural model
    model_hex  = 16'h0000;
    model_last = rd;
    for (int a = 0; a < 16; a++) begin
      model_mem[a] = 16'($urandom);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'(a), model_mem[a], 1'($urandom_range(0, 1)), rd);
    end
    for (int n = 0; n < 40; n++) begin
      logic        wr;
      logic        ub_n;
      logic        lb_n;
      logic [15:0] addr;
      logic [15:0] data;
      int          sel;
      int          idx;
      wr       = 1'($urandom_range(0, 1));
      ub_n     = 1'($urandom_range(0, 1));
      lb_n     = 1'($urandom_range(0, 1));
      data     = 16'($urandom);
      Switches = 16'($urandom);
      sel      = $urandom_range(0, 9);
      idx      = $urandom_range(0, 15);
      if (sel < 7) begin
        addr = 16'(idx);
      end else if (sel < 9) begin
        addr = 16'(1024 + $urandom_range(0, 64509));
      end else begin
        addr = IO_ADDR;
      end
      applyStimulus(wr, ub_n, lb_n, addr, data, 1'($urandom_range(0, 1)), rd);
      if (wr) begin
        if (addr == IO_ADDR) begin
          model_hex = merge(model_hex, data, ub_n, lb_n);
        end else if (int'(addr) < 1024) begin
          model_mem[int'(addr)] = merge(model_mem[int'(addr)], data, ub_n, lb_n);
        end
      end else begin
        if (addr == IO_ADDR) begin
          model_last = Switches;
        end else if (int'(addr) < 1024) begin
          model_last = model_mem[int'(addr)];
        end else begin
          model_last = 16'h0000;
        end
      end
      checkOutput($sformatf("rand%0d_data", n), rd, model_last);
      checkOutput($sformatf("rand%0d_hex", n), HEX_Data, model_hex);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
